// File: rtl/led_pwm_dimmer_pkg.sv
// Package led_pkg: CSR addresses, default widths and reset values shared by
// the LED PWM dimmer and its timebase.
package led_pkg;

  localparam int unsigned LED_NUM_LEDS  = 10;
  localparam int unsigned LED_PWM_BITS  = 8;
  localparam int unsigned LED_CSR_AW    = 2;
  localparam int unsigned LED_CSR_DW    = 32;
  localparam int unsigned LED_PRESC_W   = 16;
  localparam int unsigned LED_BLINK_W   = 8;

  typedef logic [LED_CSR_AW-1:0] led_csr_addr_t;

  localparam led_csr_addr_t LED_ADDR_DUTY       = 2'd0;
  localparam led_csr_addr_t LED_ADDR_PRESCALE   = 2'd1;
  localparam led_csr_addr_t LED_ADDR_BLINK_MASK = 2'd2;
  localparam led_csr_addr_t LED_ADDR_BLINK_HALF = 2'd3;

  localparam logic [LED_PRESC_W-1:0] LED_PRESCALE_RST   = 16'd195;
  localparam logic [LED_BLINK_W-1:0] LED_BLINK_HALF_RST = 8'd0;

endpackage : led_pkg

// File: rtl/led_pwm_dimmer_if.sv
// Avalon-MM CSR bus for the LED PWM dimmer.
//   address/chipselect/read/write/writedata : master -> slave
//   readdata                                : slave -> master (registered in slave)
interface led_pwm_dimmer_if;
  import led_pkg::*;

  led_csr_addr_t           address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [LED_CSR_DW-1:0]   writedata;
  logic [LED_CSR_DW-1:0]   readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );

endinterface : led_pwm_dimmer_if

// File: rtl/led_pwm_dimmer_timebase.sv
// led_pwm_timebase: prescaler plus PWM frame counter.
//   clk, reset_n    : clock, async active-low reset
//   prescale        : wrap value of the prescaler (counts 0..prescale)
//   prescale_clr    : clears the prescaler on the next edge
//   tick_c          : combinational, high in the cycle the prescaler wraps
//   frame_start_c   : combinational, tick_c while pwm_cnt is all-ones
//   pwm_cnt         : registered PWM position within the frame
module led_pwm_timebase
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = LED_PWM_BITS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LED_PRESC_W-1:0] prescale,
  input  logic                   prescale_clr,
  output logic                   tick_c,
  output logic                   frame_start_c,
  output logic [PWM_BITS-1:0]    pwm_cnt
);

  logic [LED_PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_BITS-1:0]    pwm_cnt_q,   pwm_cnt_d;

  assign tick_c        = (presc_cnt_q == prescale);
  assign frame_start_c = tick_c & (pwm_cnt_q == '1);
  assign pwm_cnt       = pwm_cnt_q;

  // Prescaler wraps at prescale; a PRESCALE write restarts it from zero.
  always_comb begin
    presc_cnt_d = presc_cnt_q + LED_PRESC_W'(1);
    pwm_cnt_d   = pwm_cnt_q;
    if (tick_c) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    end
    if (prescale_clr) begin
      presc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

endmodule : led_pwm_timebase

// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer: global PWM brightness (and optional per-LED blink) applied
// to the LED register block's led_out word before it reaches the pins.
//   clk, reset_n : clock, async active-low reset
//   csr          : Avalon-MM CSR slave (DUTY, PRESCALE, BLINK_MASK, BLINK_HALF)
//   led_in       : LED on/off pattern
//   led_pwm      : registered LED pin drive, 2 clk after led_in
// Optional feature macro: LED_PWM_BLINK_EN (per-LED blink). Without it the
// blink registers read 0, ignore writes and no blink logic exists.
module led_pwm_dimmer
  import led_pkg::*;
#(
  parameter int unsigned            NUM_LEDS     = LED_NUM_LEDS,
  parameter int unsigned            PWM_BITS     = LED_PWM_BITS,
  parameter logic [LED_PRESC_W-1:0] PRESCALE_RST = LED_PRESCALE_RST
) (
  input  logic                clk,
  input  logic                reset_n,
  led_pwm_dimmer_if.slave     csr,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_pwm
);

  logic                   wr_en_c;
  logic                   rd_en_c;
  logic                   prescale_clr_c;
  logic                   tick_c;
  logic                   frame_start_c;
  logic                   on_c;
  logic [PWM_BITS-1:0]    pwm_cnt;

  logic [PWM_BITS-1:0]    duty_q,       duty_d;
  logic [LED_PRESC_W-1:0] prescale_q,   prescale_d;
  logic [LED_CSR_DW-1:0]  readdata_q,   readdata_d;
  logic [PWM_BITS-1:0]    duty_act_q,   duty_act_d;
  logic                   first_tick_q, first_tick_d;
  logic [NUM_LEDS-1:0]    led_in_q,     led_in_d;
  logic [NUM_LEDS-1:0]    led_pwm_q,    led_pwm_d;

  logic                   blink_phase_c;
  logic [NUM_LEDS-1:0]    blink_mask_c;
  logic [LED_BLINK_W-1:0] blink_half_c;

  logic                   unused_wdata_c;

  assign unused_wdata_c = ^csr.writedata[LED_CSR_DW-1:LED_PRESC_W];

  // A same-cycle write takes precedence over a read.
  assign wr_en_c        = csr.chipselect & csr.write;
  assign rd_en_c        = csr.chipselect & csr.read & ~csr.write;
  assign prescale_clr_c = wr_en_c & (csr.address == LED_ADDR_PRESCALE);

  led_pwm_timebase #(
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk           (clk),
    .reset_n       (reset_n),
    .prescale      (prescale_q),
    .prescale_clr  (prescale_clr_c),
    .tick_c        (tick_c),
    .frame_start_c (frame_start_c),
    .pwm_cnt       (pwm_cnt)
  );

  // CSR write decode and registered read mux.
  always_comb begin
    duty_d     = duty_q;
    prescale_d = prescale_q;
    readdata_d = '0;
    if (wr_en_c && (csr.address == LED_ADDR_DUTY)) begin
      duty_d = csr.writedata[PWM_BITS-1:0];
    end
    if (wr_en_c && (csr.address == LED_ADDR_PRESCALE)) begin
      prescale_d = csr.writedata[LED_PRESC_W-1:0];
    end
    if (rd_en_c) begin
      case (csr.address)
        LED_ADDR_DUTY:       readdata_d = LED_CSR_DW'(duty_q);
        LED_ADDR_PRESCALE:   readdata_d = LED_CSR_DW'(prescale_q);
        LED_ADDR_BLINK_MASK: readdata_d = LED_CSR_DW'(blink_mask_c);
        LED_ADDR_BLINK_HALF: readdata_d = LED_CSR_DW'(blink_half_c);
        default:             readdata_d = '0;
      endcase
    end
  end

  // Active duty only changes at a frame boundary so the pulse never glitches.
  assign on_c = (duty_act_q == '1) | (pwm_cnt < duty_act_q);

  always_comb begin
    duty_act_d   = duty_act_q;
    first_tick_d = first_tick_q;
    if (tick_c) begin
      first_tick_d = 1'b0;
      if (frame_start_c || first_tick_q) begin
        duty_act_d = duty_q;
      end
    end
    led_in_d  = led_in;
    led_pwm_d = led_in_q & {NUM_LEDS{on_c}} & ~(blink_mask_c & {NUM_LEDS{blink_phase_c}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q       <= '1;
      prescale_q   <= PRESCALE_RST;
      readdata_q   <= '0;
      duty_act_q   <= '1;
      first_tick_q <= 1'b1;
      led_in_q     <= '0;
      led_pwm_q    <= '0;
    end else begin
      duty_q       <= duty_d;
      prescale_q   <= prescale_d;
      readdata_q   <= readdata_d;
      duty_act_q   <= duty_act_d;
      first_tick_q <= first_tick_d;
      led_in_q     <= led_in_d;
      led_pwm_q    <= led_pwm_d;
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [NUM_LEDS-1:0]    blink_mask_q,  blink_mask_d;
  logic [LED_BLINK_W-1:0] blink_half_q,  blink_half_d;
  logic [LED_BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d;

  // Blink phase toggles every BLINK_HALF frames; BLINK_HALF=0 parks it off.
  always_comb begin
    blink_mask_d  = blink_mask_q;
    blink_half_d  = blink_half_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (blink_half_q == '0) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (frame_start_c) begin
      if (blink_cnt_q == (blink_half_q - LED_BLINK_W'(1))) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + LED_BLINK_W'(1);
      end
    end
    if (wr_en_c && (csr.address == LED_ADDR_BLINK_MASK)) begin
      blink_mask_d = csr.writedata[NUM_LEDS-1:0];
    end
    if (wr_en_c && (csr.address == LED_ADDR_BLINK_HALF)) begin
      blink_half_d = csr.writedata[LED_BLINK_W-1:0];
      blink_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask_q  <= '0;
      blink_half_q  <= LED_BLINK_HALF_RST;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_mask_q  <= blink_mask_d;
      blink_half_q  <= blink_half_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_phase_c = blink_phase_q;
  assign blink_mask_c  = blink_mask_q;
  assign blink_half_c  = blink_half_q;
`else
  assign blink_phase_c = 1'b0;
  assign blink_mask_c  = '0;
  assign blink_half_c  = '0;
`endif

  assign csr.readdata = readdata_q;
  assign led_pwm      = led_pwm_q;

endmodule : led_pwm_dimmer

// File: tb/tb_led_pwm_dimmer.sv
// Self-checking bench for led_pwm_dimmer: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the dimmer.
module tb_led_pwm_dimmer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] led_in = '0;
  logic [9:0] led_pwm;

  led_pwm_dimmer_if csr_if();

  led_pwm_dimmer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .csr     (csr_if),
    .led_in  (led_in),
    .led_pwm (led_pwm)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_duty = 255, m_presc = 195, m_bmask = 0, m_bhalf = 0;
  int unsigned m_pc = 0, m_cnt = 0, m_da = 255, m_ledq = 0, m_bcnt = 0;
  bit          m_first = 1'b1, m_phase = 1'b0;
  logic [9:0]  exp_led = '0;
  logic [31:0] exp_rd = '0;

  wire         m_tick = (m_pc == m_presc);
  wire         m_fs   = m_tick && (m_cnt == 255);
  wire         m_on   = (m_da == 255) || (m_cnt < m_da);
  wire         m_wr   = csr_if.chipselect && csr_if.write;
  wire         m_rd   = csr_if.chipselect && csr_if.read && !csr_if.write;
  wire [1:0]   m_a    = csr_if.address;
  wire [31:0]  m_wd   = csr_if.writedata;

  function automatic int unsigned reg_val(input logic [1:0] a);
    case (a)
      2'd0: return m_duty;
      2'd1: return m_presc;
`ifdef LED_PWM_BLINK_EN
      2'd2: return m_bmask;
      2'd3: return m_bhalf;
`endif
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_duty <= 255; m_presc <= 195; m_bmask <= 0; m_bhalf <= 0;
      m_pc <= 0; m_cnt <= 0; m_da <= 255; m_first <= 1'b1; m_ledq <= 0;
      m_phase <= 1'b0; m_bcnt <= 0; exp_led <= '0; exp_rd <= '0;
    end else begin
      exp_led <= m_on ? 10'(m_ledq & ~(m_phase ? m_bmask : 0)) : 10'd0;
      m_ledq  <= 32'(led_in);
      exp_rd  <= m_rd ? reg_val(m_a) : 32'd0;
      if (m_tick && (m_fs || m_first)) m_da <= m_duty;
      if (m_tick) m_first <= 1'b0;
      if (m_wr && m_a == 2'd1) m_pc <= 0;
      else if (m_tick)         m_pc <= 0;
      else                     m_pc <= m_pc + 1;
      if (m_tick) m_cnt <= (m_cnt + 1) % 256;
      if (m_wr && m_a == 2'd0) m_duty  <= m_wd & 32'hFF;
      if (m_wr && m_a == 2'd1) m_presc <= m_wd & 32'hFFFF;
`ifdef LED_PWM_BLINK_EN
      if (m_wr && m_a == 2'd2) m_bmask <= m_wd & 32'h3FF;
      if (m_wr && m_a == 2'd3) m_bhalf <= m_wd & 32'hFF;
      if (m_bhalf == 0) begin
        m_bcnt <= 0; m_phase <= 1'b0;
      end else if (m_fs) begin
        if (m_bcnt == m_bhalf - 1) begin m_bcnt <= 0; m_phase <= !m_phase; end
        else m_bcnt <= m_bcnt + 1;
      end
      if (m_wr && m_a == 2'd3) m_bcnt <= 0;
`endif
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    check("led_pwm_model", 32'(led_pwm), 32'(exp_led));
    check("readdata_model", csr_if.readdata, exp_rd);
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic bus_idle();
    csr_if.chipselect = 1'b0; csr_if.read = 1'b0; csr_if.write = 1'b0;
    csr_if.address = 2'd0; csr_if.writedata = '0;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    csr_if.chipselect = 1'b1; csr_if.write = 1'b1; csr_if.read = 1'b0;
    csr_if.address = a; csr_if.writedata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    csr_if.chipselect = 1'b1; csr_if.read = 1'b1; csr_if.write = 1'b0;
    csr_if.address = a;
    @(negedge clk);
    bus_idle();
    d = csr_if.readdata;
  endtask

  task automatic wait_cnt(input int unsigned v);
    bit hit = 1'b0;
    for (int i = 0; i < 4096 && !hit; i++) begin
      if (m_cnt == v) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) check("wait_cnt_timeout", 32'(m_cnt), 32'(v));
  endtask

  // Pass at least one frame boundary, leaving the run at pwm_cnt==1.
  task automatic settle();
    wait_cnt(1);
    @(negedge clk);
    wait_cnt(1);
  endtask

  // Counts cycles where led_pwm equals pat over n cycles.
  task automatic count_pat(input logic [9:0] pat, input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      if (led_pwm == pat) hits++;
      @(negedge clk);
    end
  endtask

  task automatic count_bit(input int b, input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      if (led_pwm[b]) hits++;
      @(negedge clk);
    end
  endtask

  logic [31:0] rd;
  int          hits, hits1;

  initial begin
    bus_idle();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led_pwm", 32'(led_pwm), 32'h0);
    check("reset_readdata", csr_if.readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    csr_read(2'd0, rd);
    check("reset_duty_read", rd, 32'h0000_00FF);
    csr_read(2'd1, rd);
    check("reset_prescale_read", rd, 32'd195);

    // Duty 0x40 at PRESCALE=0: 64 of 256 cycles fully on.
    csr_write(2'd1, 32'd0);
    csr_write(2'd0, 32'h40);
    led_in = 10'h3FF;
    settle();
    count_pat(10'h3FF, 256, hits);
    check("duty40_high", 32'(hits), 32'd64);

    // Async reset mid-frame while the LEDs are lit.
    wait_cnt(32'h20);
    check("pre_reset_on", 32'(led_pwm), 32'h3FF);
    #2 reset_n = 1'b0;
    #1 check("async_reset_led", 32'(led_pwm), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    csr_read(2'd0, rd);
    check("post_reset_duty", rd, 32'hFF);

    // Mid-frame DUTY update only takes effect at the next frame.
    csr_write(2'd1, 32'd0);
    csr_write(2'd0, 32'h40);
    settle();
    hits = 0;
    for (int i = 0; i < 256; i++) begin
      if (led_pwm == 10'h3FF) hits++;
      if (m_cnt == 32'h10) begin
        csr_if.chipselect = 1'b1; csr_if.write = 1'b1;
        csr_if.address = 2'd0; csr_if.writedata = 32'hC0;
      end else begin
        bus_idle();
      end
      @(negedge clk);
    end
    bus_idle();
    check("midframe_cur", 32'(hits), 32'd64);
    count_pat(10'h3FF, 256, hits);
    check("midframe_next", 32'(hits), 32'd192);

    // Extremes.
    csr_write(2'd0, 32'h00);
    settle();
    count_pat(10'h000, 256, hits);
    check("duty00_off", 32'(hits), 32'd256);
    csr_write(2'd0, 32'hFF);
    settle();
    led_in = 10'h155;
    @(negedge clk);
    check("lat_1clk", 32'(led_pwm), 32'h3FF);
    @(negedge clk);
    check("lat_2clk", 32'(led_pwm), 32'h155);
    count_pat(10'h155, 300, hits);
    check("dutyFF_on", 32'(hits), 32'd300);

    // Read/write collision.
    csr_if.chipselect = 1'b1; csr_if.read = 1'b1; csr_if.write = 1'b1;
    csr_if.address = 2'd0; csr_if.writedata = 32'h20;
    @(negedge clk);
    bus_idle();
    check("collision_rd", csr_if.readdata, 32'h0);
    csr_read(2'd0, rd);
    check("collision_val", rd, 32'h20);

    // Blink (or its absence).
    csr_write(2'd0, 32'hFF);
    csr_write(2'd2, 32'h001);
    csr_write(2'd3, 32'd2);
    led_in = 10'h3FF;
    csr_read(2'd2, rd);
`ifdef LED_PWM_BLINK_EN
    check("blink_mask_read", rd, 32'h1);
`else
    check("blink_mask_read", rd, 32'h0);
`endif
    settle();
    settle();
    count_bit(0, 1024, hits);
    count_bit(9, 1024, hits1);
`ifdef LED_PWM_BLINK_EN
    check("blink_led0", 32'(hits), 32'd512);
`else
    check("blink_led0", 32'(hits), 32'd1024);
`endif
    check("blink_led9", 32'(hits1), 32'd1024);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        csr_if.chipselect = 1'b1;
        csr_if.read       = 1'($urandom_range(0, 1));
        csr_if.write      = 1'($urandom_range(0, 1));
        csr_if.address    = 2'($urandom_range(0, 3));
        case (csr_if.address)
          2'd1:    csr_if.writedata = $urandom_range(0, 2);
          2'd3:    csr_if.writedata = $urandom_range(0, 3);
          default: csr_if.writedata = $urandom;
        endcase
      end else begin
        bus_idle();
      end
      if ($urandom_range(0, 15) == 0) led_in = 10'($urandom);
      if ($urandom_range(0, 1999) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus_idle();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_led_pwm_dimmer
